conv_mac_accum: RTL and testbench
=================================

Name: conv_mac_accum

Overview:
- Downstream consumer of the IFMD read-address generator.
- Takes the IFMD pixel stream returned by the feature-map SRAM, one kernel tap per cycle, and multiplies each pixel by the matching weight from an internal 25-entry kernel register file.
- Accumulates each 3x3 or 5x5 window and writes one saturated, optionally ReLU'd OFMD value per window into the OFMD buffer, with a sequential write address.

Parameters:
- IFMD_H, 8, IFMD height in pixels
- IFMD_W, 8, IFMD width in pixels
- DATA_W, 8, signed pixel and weight width
- ACC_W, 21, signed accumulator width (2*DATA_W + 5; must hold 25 products)
- OUT_W, 16, signed OFMD output width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- enable  in  1  run; low = synchronous abort and clear of datapath state
- is_5x5  in  1  1 = 5x5 kernel, 0 = 3x3 kernel
- relu_en  in  1  1 = clamp negative outputs to 0
- in_valid  in  1  ifmd_data holds a valid tap this cycle
- in_last  in  1  last tap of the current window; qualified by in_valid
- ifmd_data  in  DATA_W  signed pixel from SRAM
- wgt_wr_en  in  1  kernel weight write strobe
- wgt_wr_addr  in  5  weight index 0..24, row-major
- wgt_wr_data  in  DATA_W  signed weight
- ofmd_wr_en  out  1  one-cycle write strobe
- ofmd_wr_addr  out  6  OFMD address: 0..35 for 3x3, 0..15 for 5x5
- ofmd_data  out  OUT_W  signed result
- frame_done  out  1  pulse coincident with the final OFMD write of a frame
- tap_err  out  1  sticky window-length error flag

Behaviour:
Reset (rst=0, async):
- All outputs are 0.
- Tap counter, pipeline valids, accumulator, OFMD address counter and all 25 weights are 0.

Weights:
- A write is taken when wgt_wr_en=1 and wgt_wr_addr<25.
- Addresses 25..31 are ignored.
- A write in the same cycle as a tap read of that index: the tap uses the old value; the new value applies next cycle.
- Weights are unaffected by enable.

Mode:
- mode_q is latched from is_5x5 only while the block is idle: tap=0, OFMD addr=0, no stage valid.
- Mid-frame changes of is_5x5 are ignored.
- Derived values: taps = 9/25; OFMD count = 36/16 (from IFMD_H/IFMD_W).

Stage 0 (cycle t), on in_valid:
- prod_q <= ifmd_data * w[tap], signed, 2*DATA_W bits.
- v1 <= in_valid.
- l1 <= in_valid & in_last.
- tap <= in_last ? 0 : tap+1.
- tap never exceeds taps-1: on reaching taps-1 without in_last, it wraps to 0 and sets tap_err.
- in_last with tap != taps-1 sets tap_err.
- in_last and in_valid=0: in_last is ignored.

Stage 1 (t+1), on v1:
- acc <= (first ? 0 : acc) + sign-extended prod_q.
- first is 1 after reset, after abort, and after any l1; it is cleared otherwise.

Output (t+2), when l1 was set at t+1:
- ofmd_wr_en = 1 for one cycle.
- ofmd_data = sat(acc_next), where:
  - sat clamps to [-2^(OUT_W-1), 2^(OUT_W-1)-1];
  - then, if relu_en, negative values become 0.
- ofmd_wr_addr = the current counter value; the counter increments after the write.
- On the write at addr = count-1: frame_done = 1 for that cycle and the counter wraps to 0.

Timing:
- Latency: in_last sampled at cycle t → ofmd_wr_en high at cycle t+2.
- Back-to-back windows (next tap at t+1) are supported with no bubble.
- Throughput is 1 tap per cycle.

Abort (enable=0):
- Next edge clears tap, v1, l1, acc, the first flag (to 1), OFMD addr, ofmd_wr_en and frame_done.
- Taps presented while enable=0 are discarded.
- tap_err and the weights hold.

tap_err:
- Cleared only by reset.
- Output is still written on an errored in_last.

Test Plan:
- Weights 0..8 = 1; 3x3; data 1..9 with in_last on 9th → ofmd_wr_en 2 cycles after in_last, ofmd_data=45, addr=0, tap_err=0.
- 5x5; all weights 127; 25 taps of 127 (sum 403225) → ofmd_data=32767; repeat with data -128 (sum -406400) → -32768, or 0 with relu_en=1.
- 3x3; 36 back-to-back windows with weight[4]=1, others 0, centre pixel = window index → writes at addr 0..35 with data 0..35, frame_done only on addr 35, next window writes addr 0.
- in_last asserted on 5th tap (3x3) → tap_err=1 and sticky; output = partial sum; next window starts at tap 0 and its sum is correct.
- Drop enable at tap 4 of window 3, re-raise and send a full window → writes addr 0 with the correct sum; no stray ofmd_wr_en; weights retained.
- Assert rst mid-window asynchronously → all outputs 0 immediately, before the next clk edge; weights read back as 0 (a window gives 0).

Source files
------------

// File: rtl/conv_mac_accum.sv
// conv_mac_accum: pixel x weight MAC over 3x3/5x5 windows, writes saturated optional-ReLU OFMD values
module conv_mac_accum #(
  parameter int IFMD_H = 8,
  parameter int IFMD_W = 8,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 21,
  parameter int OUT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     is_5x5,
  input  logic                     relu_en,
  input  logic                     in_valid,
  input  logic                     in_last,
  input  logic signed [DATA_W-1:0] ifmd_data,
  input  logic                     wgt_wr_en,
  input  logic [4:0]               wgt_wr_addr,
  input  logic signed [DATA_W-1:0] wgt_wr_data,
  output logic                     ofmd_wr_en,
  output logic [5:0]               ofmd_wr_addr,
  output logic signed [OUT_W-1:0]  ofmd_data,
  output logic                     frame_done,
  output logic                     tap_err
);
  localparam logic [5:0] CNT3 = 6'((IFMD_H - 2) * (IFMD_W - 2));
  localparam logic [5:0] CNT5 = 6'((IFMD_H - 4) * (IFMD_W - 4));
  localparam logic signed [ACC_W-1:0] SMAX = ACC_W'(2 ** (OUT_W - 1) - 1);
  localparam logic signed [ACC_W-1:0] SMIN = ACC_W'(-(2 ** (OUT_W - 1)));
  logic signed [DATA_W-1:0]   w_q [25];
  logic signed [2*DATA_W-1:0] prod_q, prod_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic signed [OUT_W-1:0]    sat_d, res_d, data_q;
  logic [4:0] tap_q, last_tap;
  logic [5:0] addr_q, waddr_q, cnt_m1;
  logic       mode_q, mode_d, idle, v1_q, l1_q, first_q, wr_en_q, fd_q, err_q;
  // Mode may only follow is_5x5 while nothing is in flight, so a frame never switches kernel size.
  always_comb begin
    idle     = tap_q == 5'd0 && addr_q == 6'd0 && !v1_q && !l1_q;
    mode_d   = idle ? is_5x5 : mode_q;
    last_tap = mode_d ? 5'd24 : 5'd8;
    cnt_m1   = mode_d ? CNT5 - 6'd1 : CNT3 - 6'd1;
    prod_d   = ifmd_data * w_q[tap_q];
    acc_d    = (first_q ? '0 : acc_q) + {{(ACC_W - 2 * DATA_W){prod_q[2*DATA_W-1]}}, prod_q};
    sat_d    = acc_d > SMAX ? SMAX[OUT_W-1:0] : acc_d < SMIN ? SMIN[OUT_W-1:0] : acc_d[OUT_W-1:0];
    res_d    = relu_en && sat_d[OUT_W-1] ? '0 : sat_d;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 25; i++) w_q[i] <= '0;
      prod_q  <= '0;
      acc_q   <= '0;
      data_q  <= '0;
      tap_q   <= '0;
      addr_q  <= '0;
      waddr_q <= '0;
      mode_q  <= 1'b0;
      v1_q    <= 1'b0;
      l1_q    <= 1'b0;
      first_q <= 1'b1;
      wr_en_q <= 1'b0;
      fd_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (wgt_wr_en && wgt_wr_addr < 5'd25) w_q[wgt_wr_addr] <= wgt_wr_data;
      mode_q <= mode_d;
      if (!enable) begin
        tap_q   <= '0;
        v1_q    <= 1'b0;
        l1_q    <= 1'b0;
        acc_q   <= '0;
        first_q <= 1'b1;
        addr_q  <= '0;
        wr_en_q <= 1'b0;
        fd_q    <= 1'b0;
      end else begin
        v1_q <= in_valid;
        l1_q <= in_valid && in_last;
        if (in_valid) begin
          prod_q <= prod_d;
          tap_q  <= (in_last || tap_q == last_tap) ? 5'd0 : tap_q + 5'd1;
          if (in_last != (tap_q == last_tap)) err_q <= 1'b1;
        end
        if (v1_q) begin
          acc_q   <= acc_d;
          first_q <= l1_q;
        end
        wr_en_q <= l1_q;
        fd_q    <= l1_q && addr_q == cnt_m1;
        if (l1_q) begin
          data_q  <= res_d;
          waddr_q <= addr_q;
          addr_q  <= addr_q == cnt_m1 ? 6'd0 : addr_q + 6'd1;
        end
      end
    end
  end
  assign ofmd_wr_en   = wr_en_q;
  assign ofmd_wr_addr = waddr_q;
  assign ofmd_data    = data_q;
  assign frame_done   = fd_q;
  assign tap_err      = err_q;
endmodule

// File: tb/tb_conv_mac_accum.sv
// tb_conv_mac_accum: directed windows with a queued scoreboard checked by an independent output monitor
module tb_conv_mac_accum;
  logic clk = 0, rst = 0, enable = 0, is_5x5 = 0, relu_en = 0, in_valid = 0, in_last = 0, wgt_wr_en = 0;
  logic signed [7:0] ifmd_data = 0, wgt_wr_data = 0;
  logic [4:0] wgt_wr_addr = 0;
  logic ofmd_wr_en, frame_done, tap_err;
  logic [5:0] ofmd_wr_addr;
  logic signed [15:0] ofmd_data;
  int checks = 0, errors = 0, cyc = 0;
  typedef struct {int a; int d; int fd; int c;} exp_t;
  exp_t q[$];
  conv_mac_accum dut (
    .clk(clk), .rst(rst), .enable(enable), .is_5x5(is_5x5), .relu_en(relu_en),
    .in_valid(in_valid), .in_last(in_last), .ifmd_data(ifmd_data),
    .wgt_wr_en(wgt_wr_en), .wgt_wr_addr(wgt_wr_addr), .wgt_wr_data(wgt_wr_data),
    .ofmd_wr_en(ofmd_wr_en), .ofmd_wr_addr(ofmd_wr_addr), .ofmd_data(ofmd_data),
    .frame_done(frame_done), .tap_err(tap_err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic void chk(string n, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endfunction
  exp_t e;
  always @(negedge clk) begin
    if (rst && ofmd_wr_en) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL stray_write: addr %0d data %0d with nothing expected", ofmd_wr_addr, ofmd_data);
      end else begin
        e = q.pop_front();
        chk("ofmd_data", ofmd_data, e.d);
        chk("ofmd_wr_addr", ofmd_wr_addr, e.a);
        chk("frame_done", frame_done, e.fd);
        chk("write_cycle", cyc, e.c);
      end
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic tap(input int d, input bit l);
    in_valid = 1;
    ifmd_data = 8'(d);
    in_last = l;
    tick();
    in_valid = 0;
    in_last = 0;
  endtask
  task automatic push(input int a, input int d, input int fd);
    q.push_back('{a, d, fd, cyc + 2});
  endtask
  task automatic wgt(input int a, input int d);
    wgt_wr_en = 1;
    wgt_wr_addr = 5'(a);
    wgt_wr_data = 8'(d);
    tick();
    wgt_wr_en = 0;
  endtask
  // 3x3 window whose centre pixel is c; filler pixels are 7 (weights there are 0)
  task automatic win3(input int c, input bit ex, input int a, input int fd);
    for (int j = 0; j < 9; j++) begin
      if (j == 8 && ex) push(a, c, fd);
      tap(j == 4 ? c : 7, j == 8);
    end
  endtask
  task automatic abort;
    enable = 0;
    tick();
    enable = 1;
  endtask
  initial begin
    #2;
    chk("rst_wr_en", ofmd_wr_en, 0);
    chk("rst_addr", ofmd_wr_addr, 0);
    chk("rst_data", ofmd_data, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_tap_err", tap_err, 0);
    tick();
    rst = 1;
    enable = 1;
    tick();
    for (int i = 0; i < 9; i++) wgt(i, 1);
    for (int i = 1; i <= 9; i++) begin
      if (i == 9) push(0, 45, 0);
      tap(i, i == 9);
    end
    repeat (3) tick();
    chk("tap_err_after_sum45", tap_err, 0);
    is_5x5 = 1;
    abort();
    for (int i = 0; i < 25; i++) wgt(i, 127);
    for (int i = 0; i < 25; i++) begin
      if (i == 24) push(0, 32767, 0);
      tap(127, i == 24);
    end
    repeat (3) tick();
    for (int i = 0; i < 25; i++) begin
      if (i == 24) push(1, -32768, 0);
      tap(-128, i == 24);
    end
    repeat (3) tick();
    relu_en = 1;
    for (int i = 0; i < 25; i++) begin
      if (i == 24) push(2, 0, 0);
      tap(-128, i == 24);
    end
    repeat (3) tick();
    relu_en = 0;
    chk("tap_err_after_5x5", tap_err, 0);
    is_5x5 = 0;
    abort();
    for (int i = 0; i < 25; i++) wgt(i, 0);
    wgt(4, 1);
    for (int i = 0; i < 36; i++) win3(i, 1, i, i == 35 ? 1 : 0);
    win3(5, 1, 0, 0);
    repeat (3) tick();
    chk("tap_err_after_frame", tap_err, 0);
    for (int j = 0; j < 5; j++) begin
      if (j == 4) push(1, 22, 0);
      tap(j == 4 ? 22 : 10, j == 4);
    end
    repeat (3) tick();
    chk("tap_err_short_window", tap_err, 1);
    win3(9, 1, 2, 0);
    repeat (3) tick();
    chk("tap_err_sticky", tap_err, 1);
    win3(1, 1, 3, 0);
    win3(2, 1, 4, 0);
    for (int j = 0; j < 4; j++) tap(7, 0);
    enable = 0;
    tap(7, 0);
    enable = 1;
    repeat (2) tick();
    win3(13, 1, 0, 0);
    repeat (3) tick();
    win3(20, 0, 0, 0);
    @(posedge clk);
    #2;
    chk("pre_rst_wr_en", ofmd_wr_en, 1);
    chk("pre_rst_tap_err", tap_err, 1);
    rst = 0;
    #1;
    chk("async_rst_wr_en", ofmd_wr_en, 0);
    chk("async_rst_addr", ofmd_wr_addr, 0);
    chk("async_rst_data", ofmd_data, 0);
    chk("async_rst_frame_done", frame_done, 0);
    chk("async_rst_tap_err", tap_err, 0);
    tick();
    rst = 1;
    tick();
    for (int j = 0; j < 9; j++) begin
      if (j == 8) push(0, 0, 0);
      tap(5, j == 8);
    end
    for (int k = 0; k < 50 && q.size() != 0; k++) tick();
    chk("scoreboard_drained", q.size(), 0);
    chk("tap_err_final", tap_err, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
